// File: rtl/fifo_wr.sv
// fifo_wr -- write-side traffic generator for the dual-clock FIFO demo.
//
// Waits for the FIFO to drain to almost_empty, lets the flags settle for
// WAIT_CYCLES write clocks, then writes incrementing data words until the
// FIFO reports almost_full (or full). This repeats indefinitely.
//
// State table:
//   IDLE  | waiting for almost_empty (synchronised), no busy, not almost_full
//   WAIT  | settle delay; delay counter runs 0..WAIT_CYCLES-1
//   WRITE | fifo_wr_en high, one incrementing word per clock
//
// Ports:
//   wr_clk        in   write clock
//   rst_n         in   asynchronous active-low reset
//   wr_rst_busy   in   FIFO write-reset busy; forces IDLE, no writes
//   almost_empty  in   FIFO almost-empty flag (read-clock domain)
//   almost_full   in   FIFO almost-full flag (write-clock domain)
//   full          in   FIFO full flag (write-clock domain)
//   fifo_wr_en    out  registered FIFO write enable
//   fifo_wr_data  out  registered FIFO write data
//   burst_done    out  one-cycle pulse when a burst ends normally
//   burst_cnt     out  completed bursts since reset, wraps at 0xFFFF
module fifo_wr #(
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 10,
  parameter int DATA_INIT   = 0
) (
  input  logic              wr_clk,
  input  logic              rst_n,
  input  logic              wr_rst_busy,
  input  logic              almost_empty,
  input  logic              almost_full,
  input  logic              full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              burst_done,
  output logic [15:0]       burst_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [7:0]        WAIT_LAST = 8'(WAIT_CYCLES - 1);
  localparam logic [DATA_W-1:0] DATA_RST  = DATA_W'(DATA_INIT);

  state_t      state, next_state;
  logic [7:0]  dly_cnt, dly_cnt_nxt;
  logic        ae_d0, ae_d1;
  logic        burst_end;
  logic        wr_en_nxt;
  logic        done_nxt;
  logic [15:0] cnt_nxt;

  // almost_empty comes from the read clock domain
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      ae_d0 <= 1'b0;
      ae_d1 <= 1'b0;
    end else begin
      ae_d0 <= almost_empty;
      ae_d1 <= ae_d0;
    end
  end

  // A normal burst end; wr_rst_busy overrides it so an aborted burst is not counted
  assign burst_end = (state == S_WRITE) && !wr_rst_busy && (almost_full || full);

  // State register
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      dly_cnt <= 8'd0;
    end else begin
      state   <= next_state;
      dly_cnt <= dly_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    next_state  = state;
    dly_cnt_nxt = 8'd0;
    if (wr_rst_busy) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (ae_d1 && !almost_full) next_state = S_WAIT;
        end
        S_WAIT: begin
          // almost_empty dropping here does not abort the wait
          if (dly_cnt == WAIT_LAST) next_state = S_WRITE;
          else                      dly_cnt_nxt = dly_cnt + 8'd1;
        end
        S_WRITE: begin
          if (almost_full || full) next_state = S_IDLE;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    wr_en_nxt = (next_state == S_WRITE);
    done_nxt  = burst_end;
    cnt_nxt   = burst_end ? burst_cnt + 16'd1 : burst_cnt;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= DATA_RST;
      burst_done   <= 1'b0;
      burst_cnt    <= 16'd0;
    end else begin
      fifo_wr_en <= wr_en_nxt;
      burst_done <= done_nxt;
      burst_cnt  <= cnt_nxt;
      // Data advances after every presented word and carries across bursts
      if (fifo_wr_en) fifo_wr_data <= fifo_wr_data + DATA_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr.sv
// tb_fifo_wr -- directed testbench for fifo_wr with a small FIFO model
// (depth 256). The model raises almost_full once 254 words are stored, so
// the word in flight when the flag is seen is the 255th and a burst from
// empty carries 255 words. almost_empty is high at 4 words or fewer, gated
// by ae_en so the bench controls when it first rises.
module tb_fifo_wr;

  logic       wr_clk;
  logic       rst_n;
  logic       wr_rst_busy;
  logic       almost_empty;
  logic       almost_full;
  logic       full;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       burst_done;
  logic [15:0] burst_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic ae_en;
  logic rd_en;
  int   count;
  int   wr_ok, rd_ok;
  logic [7:0] wlog[$];

  fifo_wr #(
    .DATA_W(8),
    .WAIT_CYCLES(10),
    .DATA_INIT(0)
  ) dut (
    .wr_clk(wr_clk),
    .rst_n(rst_n),
    .wr_rst_busy(wr_rst_busy),
    .almost_empty(almost_empty),
    .almost_full(almost_full),
    .full(full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .burst_done(burst_done),
    .burst_cnt(burst_cnt)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  assign almost_full  = (count >= 254);
  assign full         = (count >= 256);
  assign almost_empty = ae_en && (count <= 4);

  // FIFO model: accepts a word when enabled, not busy and not full
  always @(posedge wr_clk) begin
    if (!rst_n) begin
      count <= 0;
    end else begin
      wr_ok = (fifo_wr_en && !wr_rst_busy && (count < 256)) ? 1 : 0;
      rd_ok = (rd_en && (count > 0)) ? 1 : 0;
      if (wr_ok != 0) wlog.push_back(fifo_wr_data);
      count <= count + wr_ok - rd_ok;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; wr_rst_busy = 1'b0; ae_en = 1'b0; rd_en = 1'b0;
    count = 0;
    repeat (3) @(negedge wr_clk);
    n_vec++;
    if ({fifo_wr_en, burst_done} !== 2'b00 || fifo_wr_data !== 8'h00 || burst_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_vals: got en=%b done=%b data=%0h cnt=%0d required 0/0/00/0",
               fifo_wr_en, burst_done, fifo_wr_data, burst_cnt);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge wr_clk);
    n_vec++;
    if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 8'h00) begin
      n_err++;
      $display("FAIL post_reset_idle: got en=%b data=%0h required 0/00", fifo_wr_en, fifo_wr_data);
    end
  endtask

  task automatic test_first_burst();
    int t;
    int bad;
    logic [7:0] nx;
    wlog.delete();
    ae_en = 1'b1;
    repeat (12) @(posedge wr_clk);
    @(negedge wr_clk);
    n_vec++;
    if (fifo_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: en=%b after 12 cycles, required 0", fifo_wr_en);
    end
    @(posedge wr_clk);
    @(negedge wr_clk);
    n_vec++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h00) begin
      n_err++;
      $display("FAIL latency_13: en=%b data=%0h, required 1/00", fifo_wr_en, fifo_wr_data);
    end
    @(negedge wr_clk);
    n_vec++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h01) begin
      n_err++;
      $display("FAIL second_word: en=%b data=%0h, required 1/01", fifo_wr_en, fifo_wr_data);
    end
    t = 0;
    while (burst_done !== 1'b1 && t < 400) begin
      @(negedge wr_clk);
      t++;
    end
    n_vec++;
    if (t >= 400) begin
      n_err++;
      $display("FAIL burst1_timeout: burst_done not seen in 400 cycles");
    end
    n_vec++;
    if (fifo_wr_en !== 1'b0 || burst_cnt !== 16'd1 || fifo_wr_data !== 8'hFF) begin
      n_err++;
      $display("FAIL burst1_end: en=%b cnt=%0d data=%0h, required 0/1/ff",
               fifo_wr_en, burst_cnt, fifo_wr_data);
    end
    bad = 0;
    if (wlog.size() != 255) bad = 1000;
    else begin
      if (wlog[0] !== 8'h00 || wlog[254] !== 8'hFE) bad++;
      for (int i = 1; i < 255; i++) begin
        nx = wlog[i-1] + 8'd1;
        if (wlog[i] !== nx) bad++;
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL burst1_words: %0d words written, %0d bad, required 255 words 00..fe",
               wlog.size(), bad);
    end
    @(negedge wr_clk);
    n_vec++;
    if (burst_done !== 1'b0 || burst_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL done_pulse_width: done=%b cnt=%0d, required 0/1", burst_done, burst_cnt);
    end
  endtask

  // Drain the model FIFO completely, then stop reading
  task automatic drain();
    int t;
    rd_en = 1'b1;
    t = 0;
    while (count != 0 && t < 400) begin
      @(negedge wr_clk);
      t++;
    end
    rd_en = 1'b0;
    n_vec++;
    if (t >= 400) begin
      n_err++;
      $display("FAIL drain_timeout: count=%0d, required 0", count);
    end
  endtask

  task automatic test_wrap_burst();
    int t;
    int bad;
    logic [7:0] nx;
    wlog.delete();
    drain();
    t = 0;
    while (burst_done !== 1'b1 && t < 400) begin
      @(negedge wr_clk);
      t++;
    end
    n_vec++;
    if (t >= 400 || burst_cnt !== 16'd2 || fifo_wr_data !== 8'hFE) begin
      n_err++;
      $display("FAIL burst2_end: t=%0d cnt=%0d data=%0h, required cnt 2 data fe",
               t, burst_cnt, fifo_wr_data);
    end
    bad = 0;
    if (wlog.size() != 255) bad = 1000;
    else begin
      if (wlog[0] !== 8'hFF || wlog[1] !== 8'h00) bad++;
      for (int i = 1; i < 255; i++) begin
        nx = wlog[i-1] + 8'd1;
        if (wlog[i] !== nx) bad++;
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL burst2_wrap: %0d words written, %0d bad, required 255 words ff,00..fd",
               wlog.size(), bad);
    end
  endtask

  task automatic test_busy_abort();
    int t;
    int seen;
    drain();
    t = 0;
    while (fifo_wr_en !== 1'b1 && t < 50) begin
      @(negedge wr_clk);
      t++;
    end
    n_vec++;
    if (t >= 50 || fifo_wr_data !== 8'hFE) begin
      n_err++;
      $display("FAIL burst3_start: t=%0d data=%0h, required data fe", t, fifo_wr_data);
    end
    repeat (3) @(negedge wr_clk);
    wr_rst_busy = 1'b1;
    @(negedge wr_clk);
    n_vec++;
    if (fifo_wr_en !== 1'b0 || burst_done !== 1'b0 || fifo_wr_data !== 8'h02 || burst_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL busy_abort: en=%b done=%b data=%0h cnt=%0d, required 0/0/02/2",
               fifo_wr_en, burst_done, fifo_wr_data, burst_cnt);
    end
    seen = 0;
    repeat (4) begin
      @(negedge wr_clk);
      if (fifo_wr_en !== 1'b0 || burst_done !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0 || fifo_wr_data !== 8'h02) begin
      n_err++;
      $display("FAIL busy_hold: %0d active cycles data=%0h, required 0 and 02", seen, fifo_wr_data);
    end
    wr_rst_busy = 1'b0;
    repeat (10) @(posedge wr_clk);
    @(negedge wr_clk);
    n_vec++;
    if (fifo_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL resume_early: en=%b after 10 cycles, required 0", fifo_wr_en);
    end
    @(posedge wr_clk);
    @(negedge wr_clk);
    n_vec++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h02) begin
      n_err++;
      $display("FAIL resume_11: en=%b data=%0h, required 1/02", fifo_wr_en, fifo_wr_data);
    end
    t = 0;
    while (burst_done !== 1'b1 && t < 400) begin
      @(negedge wr_clk);
      t++;
    end
    n_vec++;
    if (t >= 400 || burst_cnt !== 16'd3 || fifo_wr_data !== 8'hFE) begin
      n_err++;
      $display("FAIL burst3_end: t=%0d cnt=%0d data=%0h, required cnt 3 data fe",
               t, burst_cnt, fifo_wr_data);
    end
  endtask

  task automatic test_async_reset();
    int t;
    drain();
    t = 0;
    while (fifo_wr_en !== 1'b1 && t < 50) begin
      @(negedge wr_clk);
      t++;
    end
    repeat (5) @(negedge wr_clk);
    n_vec++;
    if (t >= 50 || fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h03) begin
      n_err++;
      $display("FAIL burst4_pre_reset: t=%0d en=%b data=%0h, required 1/03", t, fifo_wr_en, fifo_wr_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({fifo_wr_en, burst_done} !== 2'b00 || fifo_wr_data !== 8'h00 || burst_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: en=%b done=%b data=%0h cnt=%0d, required 0/0/00/0",
               fifo_wr_en, burst_done, fifo_wr_data, burst_cnt);
    end
  endtask

  task automatic test_busy_from_reset();
    int seen;
    wr_rst_busy = 1'b1;
    ae_en = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge wr_clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge wr_clk);
      if (fifo_wr_en !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL busy_from_reset: en high %0d cycles, required 0", seen);
    end
    wr_rst_busy = 1'b0;
    repeat (10) @(posedge wr_clk);
    @(negedge wr_clk);
    n_vec++;
    if (fifo_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL busy_release_early: en=%b after 10 cycles, required 0", fifo_wr_en);
    end
    @(posedge wr_clk);
    @(negedge wr_clk);
    n_vec++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h00) begin
      n_err++;
      $display("FAIL busy_release_11: en=%b data=%0h, required 1/00", fifo_wr_en, fifo_wr_data);
    end
  endtask

  initial begin
    test_reset();
    test_first_burst();
    test_wrap_burst();
    test_busy_abort();
    test_async_reset();
    test_busy_from_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
